vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised multi-mode test-pattern generator for the HDMI/VGA output path. It sits between the timing generator (col_addr, row_addr, ready) and the TMDS encoder.
- Modes: N-band colour bars (horizontal or vertical bands), checkerboard, grey ramp, and solid colour.
- Mode and settings are latched per frame. Output is a 2-stage registered pipeline with an aligned data-enable.

Parameters:
- COLOR_W, 8, bits per colour channel
- ADDR_W, 11, width of col_addr/row_addr
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- NUM_BARS, 8, colour-bar count, legal 1..16
- CHECK_LOG2, 5, checker cell size = 2^CHECK_LOG2 pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- col_addr  in  ADDR_W  current pixel column
- row_addr  in  ADDR_W  current pixel row
- ready  in  1  active-video qualifier
- frame_start  in  1  one-cycle pulse before the first active pixel of a frame
- mode  in  2  requested pattern: 0 bars, 1 checker, 2 ramp, 3 solid
- vertical  in  1  bars: 0 = bands stacked by row, 1 = bands side by side by column
- solid_rgb  in  3*COLOR_W  {R,G,B} for mode 3
- R, G, B  out  COLOR_W each  pixel colour
- de_out  out  1  ready delayed to align with R/G/B
- cur_mode  out  2  mode currently in effect
- frame_cnt  out  8  frame counter

Behaviour:
- Reset (async, rst=1): R=G=B=0, de_out=0, cur_mode=0, frame_cnt=0, latched vertical=0, latched solid=0, bar idx=0, boundary=BAR_LEN.
- Frame latch: on frame_start, capture mode, vertical and solid_rgb into shadow registers, and increment frame_cnt (255 wraps to 0).
  - Shadows affect pixels presented from the next cycle onward.
  - A pixel presented in the same cycle as frame_start uses the old settings.
  - Mode input changes without frame_start are ignored.
- Bar length: BAR_LEN = V_ACTIVE/NUM_BARS (vertical=0) or H_ACTIVE/NUM_BARS (vertical=1), constant at elaboration. The last bar absorbs the remainder.
- Stage 1, bar tracker (no runtime divide). axis_addr = row_addr (vertical=0) or col_addr (vertical=1). Evaluated only when ready=1:
  - if axis_addr==0: idx=0, boundary=BAR_LEN
  - else if axis_addr>=boundary and idx<NUM_BARS-1: idx+1, boundary+BAR_LEN
  - at most one step per clock; after a mid-frame reset the index catches up by one bar per clock.
- Stage 1 also registers col_addr, row_addr and ready, plus an out-of-range flag: col_addr>=H_ACTIVE or row_addr>=V_ACTIVE.
- Stage 2, colour select (registered):
  - Bars: palette index idx mod 8. F = all ones, H = MSB only, 0 = zero.
    - 0 red (F,0,0)
    - 1 orange (F,H,0)
    - 2 yellow (F,F,0)
    - 3 green (0,F,0)
    - 4 blue (0,0,F)
    - 5 violet (H,0,H)
    - 6 black (0,0,0)
    - 7 white (F,F,F)
  - Checker: c = X[CHECK_LOG2] ^ row_addr[CHECK_LOG2], with X = col_addr (see Optional Feature). c=1 white, c=0 black.
  - Ramp: R=G=B=col_addr[COLOR_W-1:0], a sawtooth that wraps every 2^COLOR_W pixels.
  - Solid: the latched solid_rgb.
- Blanking: if stage-1 ready=0 or the out-of-range flag is set, output R=G=B=0.
- de_out = stage-1 ready.
- Latency: inputs at cycle t produce R/G/B/de_out at t+2.

Optional Feature:
- Macro: PATTERN_SCROLL_EN.
- Defined: checker uses X = col_addr + frame_cnt (ADDR_W-bit wrap), giving 1 px/frame horizontal scroll. Bars use palette index (idx + frame_cnt[7:3]) mod 8, rotating the palette every 8 frames.
- Undefined: static patterns; frame_cnt still counts.

Test Plan:
- Reset, frame_start with mode=0, vertical=0, then ready=1, col 10, row 100 -> at t+2 R=FF G=80 B=00, de_out=1. Row 719 -> FF,FF,FF.
- Mode 0, ready=1, col 1280, row 5 -> R=G=B=0, de_out=1. ready=0 -> R=G=B=0, de_out=0.
- frame_start with vertical=1, sweep col 0..1279 on row 0 -> col 479 yellow (FF,FF,00), col 480 green (00,FF,00), col 1279 white.
- Mode 1, CHECK_LOG2=5 -> (col 32, row 0) white, (col 32, row 32) black. Mode 2, col 300 -> R=G=B=2C.
- Request mode=3 with solid_rgb=123456 mid-frame without frame_start -> output unchanged. After frame_start -> 12,34,56, cur_mode=3, frame_cnt incremented.
- PATTERN_SCROLL_EN, frame_cnt=3, mode 1, col 29, row 0 -> white. Assert rst mid-line at row 300, vertical=0 -> outputs 0 immediately; after release, idx reaches 3 within 3 active clocks, giving green.

Source files
------------

// File: rtl/vga_pattern_gen_if.sv
// Pixel-path bundle between the timing generator / pattern generator / TMDS encoder.
// master: drives pixel coordinates and settings; slave: the pattern generator.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 8,
    parameter int ADDR_W  = 11
);
    logic [ADDR_W-1:0]    col_addr;
    logic [ADDR_W-1:0]    row_addr;
    logic                 ready;
    logic                 frame_start;
    logic [1:0]           mode;
    logic                 vertical;
    logic [3*COLOR_W-1:0] solid_rgb;
    logic [COLOR_W-1:0]   R;
    logic [COLOR_W-1:0]   G;
    logic [COLOR_W-1:0]   B;
    logic                 de_out;
    logic [1:0]           cur_mode;
    logic [7:0]           frame_cnt;

    modport master (
        output col_addr, row_addr, ready, frame_start, mode, vertical, solid_rgb,
        input  R, G, B, de_out, cur_mode, frame_cnt
    );

    modport slave (
        input  col_addr, row_addr, ready, frame_start, mode, vertical, solid_rgb,
        output R, G, B, de_out, cur_mode, frame_cnt
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Multi-mode test-pattern generator: colour bars, checkerboard, grey ramp, solid.
// Settings are shadowed per frame; two registered stages give R/G/B/de_out at t+2.
// Optional macro PATTERN_SCROLL_EN: checker scrolls 1 px/frame, bar palette
// rotates every 8 frames. Undefined: static patterns.
module vga_pattern_gen #(
    parameter int COLOR_W    = 8,
    parameter int ADDR_W     = 11,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5
) (
    input logic              clk,
    input logic              rst,
    vga_pattern_gen_if.slave bus
);
    localparam logic [ADDR_W:0]  BAR_LEN_V = (ADDR_W+1)'(V_ACTIVE / NUM_BARS);
    localparam logic [ADDR_W:0]  BAR_LEN_H = (ADDR_W+1)'(H_ACTIVE / NUM_BARS);
    localparam logic [ADDR_W:0]  H_LIM     = (ADDR_W+1)'(H_ACTIVE);
    localparam logic [ADDR_W:0]  V_LIM     = (ADDR_W+1)'(V_ACTIVE);
    localparam logic [3:0]       LAST_IDX  = 4'(NUM_BARS - 1);
    localparam logic [COLOR_W-1:0] FULL    = '1;
    localparam logic [COLOR_W-1:0] HALF    = {1'b1, {(COLOR_W-1){1'b0}}};

    // per-frame shadow settings
    logic [1:0]           mode_q;
    logic                 vert_q;
    logic [3*COLOR_W-1:0] solid_q;
    logic [7:0]           frame_cnt_q;

    // stage 1
    logic [3:0]           idx_q, idx_d;
    logic [ADDR_W:0]      bnd_q, bnd_d;
    logic                 s1_ready_q, s1_oor_q, s1_chk_q;
    logic [COLOR_W-1:0]   s1_ramp_q;
    logic [1:0]           s1_mode_q;
    logic [3*COLOR_W-1:0] s1_solid_q;
`ifdef PATTERN_SCROLL_EN
    logic [2:0]           s1_rot_q;
    logic [ADDR_W-1:0]    chk_x;
`endif

    // stage 2
    logic [COLOR_W-1:0]   r_q, g_q, b_q, r_d, g_d, b_d;
    logic                 de_q;

    logic [ADDR_W-1:0]    axis;
    logic [ADDR_W:0]      bar_len;
    logic                 oor, chk_bit;
    logic [2:0]           pal;

    // Shadow registers: settings change only on frame_start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 2'd0;
            vert_q      <= 1'b0;
            solid_q     <= '0;
            frame_cnt_q <= 8'd0;
        end else if (bus.frame_start) begin
            mode_q      <= bus.mode;
            vert_q      <= bus.vertical;
            solid_q     <= bus.solid_rgb;
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    // Bar tracker: walks the bar index forward one step per active clock,
    // compared against a running boundary instead of dividing the address
    always_comb begin
        axis    = vert_q ? bus.col_addr : bus.row_addr;
        bar_len = vert_q ? BAR_LEN_H : BAR_LEN_V;
        idx_d   = idx_q;
        bnd_d   = bnd_q;
        if (bus.ready) begin
            if (axis == '0) begin
                idx_d = 4'd0;
                bnd_d = bar_len;
            end else if (({1'b0, axis} >= bnd_q) && (idx_q < LAST_IDX)) begin
                idx_d = idx_q + 4'd1;
                bnd_d = bnd_q + bar_len;
            end
        end
    end

    // Stage-1 per-pixel terms; the shadow values are pipelined so a pixel
    // presented alongside frame_start is still drawn with the old settings
    always_comb begin
        oor = ({1'b0, bus.col_addr} >= H_LIM) || ({1'b0, bus.row_addr} >= V_LIM);
`ifdef PATTERN_SCROLL_EN
        chk_x   = bus.col_addr + ADDR_W'(frame_cnt_q);
        chk_bit = chk_x[CHECK_LOG2] ^ bus.row_addr[CHECK_LOG2];
`else
        chk_bit = bus.col_addr[CHECK_LOG2] ^ bus.row_addr[CHECK_LOG2];
`endif
    end

    // Stage-1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= 4'd0;
            bnd_q      <= BAR_LEN_V;
            s1_ready_q <= 1'b0;
            s1_oor_q   <= 1'b0;
            s1_chk_q   <= 1'b0;
            s1_ramp_q  <= '0;
            s1_mode_q  <= 2'd0;
            s1_solid_q <= '0;
`ifdef PATTERN_SCROLL_EN
            s1_rot_q   <= 3'd0;
`endif
        end else begin
            idx_q      <= idx_d;
            bnd_q      <= bnd_d;
            s1_ready_q <= bus.ready;
            s1_oor_q   <= oor;
            s1_chk_q   <= chk_bit;
            s1_ramp_q  <= bus.col_addr[COLOR_W-1:0];
            s1_mode_q  <= mode_q;
            s1_solid_q <= solid_q;
`ifdef PATTERN_SCROLL_EN
            s1_rot_q   <= frame_cnt_q[5:3];
`endif
        end
    end

    // Colour select with blanking outside active video
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
`ifdef PATTERN_SCROLL_EN
        pal = idx_q[2:0] + s1_rot_q;
`else
        pal = idx_q[2:0];
`endif
        if (s1_ready_q && !s1_oor_q) begin
            case (s1_mode_q)
                2'd0: begin
                    case (pal)
                        3'd0: r_d = FULL;
                        3'd1: begin r_d = FULL; g_d = HALF; end
                        3'd2: begin r_d = FULL; g_d = FULL; end
                        3'd3: g_d = FULL;
                        3'd4: b_d = FULL;
                        3'd5: begin r_d = HALF; b_d = HALF; end
                        3'd6: ;
                        default: begin r_d = FULL; g_d = FULL; b_d = FULL; end
                    endcase
                end
                2'd1: begin
                    r_d = s1_chk_q ? FULL : '0;
                    g_d = s1_chk_q ? FULL : '0;
                    b_d = s1_chk_q ? FULL : '0;
                end
                2'd2: begin
                    r_d = s1_ramp_q;
                    g_d = s1_ramp_q;
                    b_d = s1_ramp_q;
                end
                default: begin
                    r_d = s1_solid_q[3*COLOR_W-1:2*COLOR_W];
                    g_d = s1_solid_q[2*COLOR_W-1:COLOR_W];
                    b_d = s1_solid_q[COLOR_W-1:0];
                end
            endcase
        end
    end

    // Stage-2 output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= s1_ready_q;
        end
    end

    assign bus.R         = r_q;
    assign bus.G         = g_q;
    assign bus.B         = b_q;
    assign bus.de_out    = de_q;
    assign bus.cur_mode  = mode_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed scenarios with literal expectations, then
// randomized sparse raster frames, all checked every cycle against a
// behavioural model of the pattern rules.
`timescale 1ns/1ps
module tb_vga_pattern_gen;
    localparam int CW = 8, AW = 11, HA = 1280, VA = 720, NB = 8, CL = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_pattern_gen_if #(.COLOR_W(CW), .ADDR_W(AW)) bus ();

    vga_pattern_gen #(
        .COLOR_W(CW), .ADDR_W(AW), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .NUM_BARS(NB), .CHECK_LOG2(CL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit valid;
        int r; int g; int b; int de; int mode; int fcnt;
    } exp_t;

    int checks = 0;
    int failures = 0;

    exp_t cur, d1, d2;

    // model state
    int m_mode, m_vert, m_solid, m_fcnt, m_idx;

    int pal_r[8] = '{255, 255, 255,   0,   0, 128, 0, 255};
    int pal_g[8] = '{  0, 128, 255, 255,   0,   0, 0, 255};
    int pal_b[8] = '{  0,   0,   0,   0, 255, 128, 0, 255};

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t zero_e();
        exp_t e;
        e.valid = 1'b1; e.r = 0; e.g = 0; e.b = 0; e.de = 0; e.mode = 0; e.fcnt = 0;
        return e;
    endfunction

    // Behavioural model: bar index is the true band (address / bar length,
    // capped at the last bar), approached by at most one bar per active clock.
    task automatic eval();
        exp_t e;
        int col, row, axis, bl, pal, x, c;
        if (rst) begin
            m_mode = 0; m_vert = 0; m_solid = 0; m_fcnt = 0; m_idx = 0;
            cur = zero_e();
            return;
        end
        e = zero_e();
        col = int'(bus.col_addr);
        row = int'(bus.row_addr);
        if (bus.ready) begin
            axis = (m_vert != 0) ? col : row;
            bl   = (m_vert != 0) ? HA / NB : VA / NB;
            if (axis == 0) m_idx = 0;
            else if ((axis / bl) > m_idx && m_idx < NB - 1) m_idx++;
        end
        e.de = int'(bus.ready);
`ifdef PATTERN_SCROLL_EN
        pal = (m_idx + m_fcnt / 8) % 8;
        x   = (col + m_fcnt) % (1 << AW);
`else
        pal = m_idx % 8;
        x   = col;
`endif
        c = ((x >> CL) ^ (row >> CL)) & 1;
        if (bus.ready && col < HA && row < VA) begin
            case (m_mode)
                0: begin e.r = pal_r[pal]; e.g = pal_g[pal]; e.b = pal_b[pal]; end
                1: begin e.r = c * 255; e.g = c * 255; e.b = c * 255; end
                2: begin e.r = col % 256; e.g = col % 256; e.b = col % 256; end
                default: begin
                    e.r = (m_solid >> 16) & 255;
                    e.g = (m_solid >> 8) & 255;
                    e.b = m_solid & 255;
                end
            endcase
        end
        if (bus.frame_start) begin
            m_mode  = int'(bus.mode);
            m_vert  = int'(bus.vertical);
            m_solid = int'(bus.solid_rgb);
            m_fcnt  = (m_fcnt + 1) % 256;
        end
        e.mode = m_mode;
        e.fcnt = m_fcnt;
        cur = e;
    endtask

    task automatic cyc(input int col, input int row, input bit rdy, input bit fs,
                       input int md, input bit vt, input int sol);
        @(posedge clk); #1;
        d2 = d1; d1 = cur;
        bus.col_addr    = col[AW-1:0];
        bus.row_addr    = row[AW-1:0];
        bus.ready       = rdy;
        bus.frame_start = fs;
        bus.mode        = md[1:0];
        bus.vertical    = vt;
        bus.solid_rgb   = sol[23:0];
        eval();
    endtask

    task automatic hold(input int col, input int row, input bit rdy, input int n);
        for (int i = 0; i < n; i++)
            cyc(col, row, rdy, 1'b0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 24'hFFFFFF)));
    endtask

    task automatic fstart(input int md, input bit vt, input int sol);
        cyc(0, 0, 1'b0, 1'b1, md, vt, sol);
        cyc(0, 0, 1'b0, 1'b0, int'($urandom_range(0, 3)), vt, 0);
    endtask

    task automatic lit(input string nm, input int r, input int g, input int b, input int de);
        @(negedge clk);
        chk({nm, "_R"}, int'(bus.R), r);
        chk({nm, "_G"}, int'(bus.G), g);
        chk({nm, "_B"}, int'(bus.B), b);
        chk({nm, "_de"}, int'(bus.de_out), de);
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        d2 = d1; d1 = cur;
        rst = 1'b0;
        eval();
    endtask

    // Per-cycle compare against the model pipeline
    always @(negedge clk) begin
        if (d2.valid) begin
            chk("pix_R", int'(bus.R), d2.r);
            chk("pix_G", int'(bus.G), d2.g);
            chk("pix_B", int'(bus.B), d2.b);
            chk("pix_de", int'(bus.de_out), d2.de);
        end
        if (d1.valid) begin
            chk("cur_mode", int'(bus.cur_mode), d1.mode);
            chk("frame_cnt", int'(bus.frame_cnt), d1.fcnt);
        end
    end

    initial begin
        int col, row;
        bit same;
        bus.col_addr = '0; bus.row_addr = '0; bus.ready = 1'b0; bus.frame_start = 1'b0;
        bus.mode = 2'd0; bus.vertical = 1'b0; bus.solid_rgb = '0;
        eval();
        d1 = cur; d2 = cur;

        hold(0, 0, 1'b0, 3);
        lit("reset", 0, 0, 0, 0);
        chk("reset_cur_mode", int'(bus.cur_mode), 0);
        chk("reset_frame_cnt", int'(bus.frame_cnt), 0);
        release_rst();

        // horizontal bands
        fstart(0, 1'b0, 0);
        hold(10, 100, 1'b1, 3);
        lit("bar_orange", 8'hFF, 8'h80, 8'h00, 1);
        hold(10, 719, 1'b1, 10);
        lit("bar_last_white", 8'hFF, 8'hFF, 8'hFF, 1);
        hold(1280, 5, 1'b1, 3);
        lit("oor_blank", 0, 0, 0, 1);
        hold(1280, 5, 1'b0, 3);
        lit("not_ready", 0, 0, 0, 0);

        // vertical bands, full sweep of row 0
        fstart(0, 1'b1, 0);
        for (int c = 0; c < 479; c++) cyc(c, 0, 1'b1, 1'b0, 0, 1'b0, 0);
        hold(479, 0, 1'b1, 3);
        lit("vbar_479_yellow", 8'hFF, 8'hFF, 8'h00, 1);
        hold(480, 0, 1'b1, 3);
        lit("vbar_480_green", 8'h00, 8'hFF, 8'h00, 1);
        for (int c = 481; c < 1279; c++) cyc(c, 0, 1'b1, 1'b0, 0, 1'b0, 0);
        hold(1279, 0, 1'b1, 3);
        lit("vbar_1279_white", 8'hFF, 8'hFF, 8'hFF, 1);

        // checker and ramp
        fstart(1, 1'b0, 0);
        hold(32, 0, 1'b1, 3);
        lit("chk_32_0", 8'hFF, 8'hFF, 8'hFF, 1);
        hold(32, 32, 1'b1, 3);
        lit("chk_32_32", 0, 0, 0, 1);
        fstart(2, 1'b0, 0);
        hold(300, 10, 1'b1, 3);
        lit("ramp_300", 8'h2C, 8'h2C, 8'h2C, 1);

        // mode request without frame_start is ignored
        for (int i = 0; i < 3; i++) cyc(300, 10, 1'b1, 1'b0, 3, 1'b0, 24'h123456);
        lit("ignored_req", 8'h2C, 8'h2C, 8'h2C, 1);
        chk("ignored_cur_mode", int'(bus.cur_mode), 2);
        fstart(3, 1'b0, 24'h123456);
        hold(300, 10, 1'b1, 3);
        lit("solid", 8'h12, 8'h34, 8'h56, 1);
        chk("solid_cur_mode", int'(bus.cur_mode), 3);
        chk("solid_frame_cnt", int'(bus.frame_cnt), 5);

        // asynchronous reset mid-line, then bar index catch-up
        fstart(0, 1'b0, 0);
        hold(50, 300, 1'b1, 6);
        lit("pre_reset_green", 8'h00, 8'hFF, 8'h00, 1);
        @(posedge clk); #1;
        d2 = d1; d1 = cur;
        rst = 1'b1;
        eval();
        d1 = cur; d2 = cur;
        #1;
        chk("rst_imm_R", int'(bus.R), 0);
        chk("rst_imm_G", int'(bus.G), 0);
        chk("rst_imm_de", int'(bus.de_out), 0);
        chk("rst_imm_frame_cnt", int'(bus.frame_cnt), 0);
        hold(50, 300, 1'b1, 2);
        release_rst();
        hold(50, 300, 1'b1, 2);
        lit("catchup_1_orange", 8'hFF, 8'h80, 8'h00, 1);
        hold(50, 300, 1'b1, 2);
        lit("catchup_3_green", 8'h00, 8'hFF, 8'h00, 1);

        // checker at frame_cnt 3
        fstart(1, 1'b0, 0);
        fstart(1, 1'b0, 0);
        fstart(1, 1'b0, 0);
        hold(29, 0, 1'b1, 3);
`ifdef PATTERN_SCROLL_EN
        lit("scroll_29", 8'hFF, 8'hFF, 8'hFF, 1);
`else
        lit("static_29", 0, 0, 0, 1);
`endif

        // randomized sparse raster frames
        for (int f = 0; f < 10; f++) begin
            hold(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b0,
                 int'($urandom_range(2, 6)));
            same = 1'($urandom_range(0, 1));
            if (!same)
                cyc(0, 0, 1'b0, 1'b1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 24'hFFFFFF)));
            row = 0;
            while (row < VA + 10) begin
                col = 0;
                while (col < HA + 10) begin
                    if (same && row == 0 && col == 0)
                        cyc(0, 0, 1'b1, 1'b1, int'($urandom_range(0, 3)), 1'(m_vert),
                            int'($urandom_range(0, 24'hFFFFFF)));
                    else
                        cyc(col, row, (col == 0) || ($urandom_range(0, 7) != 0), 1'b0,
                            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 24'hFFFFFF)));
                    col += int'($urandom_range(1, 90));
                end
                hold(col, row, 1'b0, int'($urandom_range(1, 3)));
                row += int'($urandom_range(1, 70));
            end
        end

        hold(0, 0, 1'b0, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
